// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } resp_state_e;

  localparam int   NUM_PORTS = 2;
  localparam logic CEN_ON    = 1'b0;
  localparam logic WEN_WR    = 1'b0;

endpackage

// File: rtl/sram_arb_resp_buf.sv
// rtl/sram_arb_resp_buf.sv - per-port read response tracker with a one-entry hold buffer
module sram_arb_resp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant_read,
  input  logic              ready,
  input  logic [DATA_W-1:0] q,
  output logic              resp_free,
  output logic              valid,
  output logic [DATA_W-1:0] rdata
);
  import sram_arb_pkg::*;

  resp_state_e       state;
  resp_state_e       state_next;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      hold_q <= '0;
    end else begin
      state <= state_next;
      // SRAM output is only good for one cycle, so park it when the consumer stalls
      if (state == WAIT && !ready) begin
        hold_q <= q;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_read ? WAIT : IDLE;
      WAIT:    state_next = ready ? (grant_read ? WAIT : IDLE) : HOLD;
      HOLD:    state_next = ready ? (grant_read ? WAIT : IDLE) : HOLD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_free = (state == IDLE) || ready;
    valid     = (state != IDLE) && !reset;
    rdata     = '0;
    case (state)
      WAIT:    rdata = q;
      HOLD:    rdata = hold_q;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter and sequencer for a single-port SRAM
module sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic              io_req0_write,
  input  logic [ADDR_W-1:0] io_req0_adr,
  input  logic [DATA_W-1:0] io_req0_wdata,
  input  logic [STRB_W-1:0] io_req0_wstrb,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic              io_req1_write,
  input  logic [ADDR_W-1:0] io_req1_adr,
  input  logic [DATA_W-1:0] io_req1_wdata,
  input  logic [STRB_W-1:0] io_req1_wstrb,
  output logic              io_resp0_valid,
  input  logic              io_resp0_ready,
  output logic [DATA_W-1:0] io_resp0_rdata,
  output logic              io_resp1_valid,
  input  logic              io_resp1_ready,
  output logic [DATA_W-1:0] io_resp1_rdata,
  output logic              io_sram_cen,
  output logic              io_sram_wen,
  output logic [STRB_W-1:0] io_sram_wstrb,
  output logic [ADDR_W-1:0] io_sram_adr,
  output logic [DATA_W-1:0] io_sram_d,
  input  logic [DATA_W-1:0] io_sram_q
);
  import sram_arb_pkg::*;

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_write;
  logic [NUM_PORTS-1:0] resp_free;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic                 last_grant;
  logic                 sel;

  assign req_valid = {io_req1_valid, io_req0_valid};
  assign req_write = {io_req1_write, io_req0_write};
  // A read may only go out if its response slot is empty or drains this cycle
  assign eligible  = req_valid & (req_write | resp_free);
  assign sel       = grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (&eligible) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign io_req0_ready = grant[0];
  assign io_req1_ready = grant[1];

  always_comb begin
    io_sram_cen   = ~CEN_ON;
    io_sram_wen   = ~WEN_WR;
    io_sram_wstrb = '0;
    io_sram_adr   = '0;
    io_sram_d     = '0;
    if (|grant) begin
      io_sram_cen = CEN_ON;
      io_sram_wen = req_write[sel] ? WEN_WR : ~WEN_WR;
      io_sram_adr = sel ? io_req1_adr : io_req0_adr;
      io_sram_d   = sel ? io_req1_wdata : io_req0_wdata;
      if (req_write[sel]) begin
        io_sram_wstrb = sel ? io_req1_wstrb : io_req0_wstrb;
      end
    end
  end

  sram_arb_resp_buf #(.DATA_W(DATA_W)) u_resp0 (
    .clock      (clock),
    .reset      (reset),
    .grant_read (grant[0] & ~req_write[0]),
    .ready      (io_resp0_ready),
    .q          (io_sram_q),
    .resp_free  (resp_free[0]),
    .valid      (io_resp0_valid),
    .rdata      (io_resp0_rdata)
  );

  sram_arb_resp_buf #(.DATA_W(DATA_W)) u_resp1 (
    .clock      (clock),
    .reset      (reset),
    .grant_read (grant[1] & ~req_write[1]),
    .ready      (io_resp1_ready),
    .q          (io_sram_q),
    .resp_free  (resp_free[1]),
    .valid      (io_resp1_valid),
    .rdata      (io_resp1_rdata)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and reference model
module tb_sram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  v  = 2'b00;
  logic [1:0]  w  = 2'b00;
  logic [1:0]  pr = 2'b11;
  logic [7:0]  a  [2];
  logic [31:0] wd [2];
  logic [3:0]  ws [2];

  logic        rdy0, rdy1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic        cen, wen;
  logic [3:0]  swstrb;
  logic [7:0]  sadr;
  logic [31:0] sd;
  logic [31:0] q = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sram_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .io_req0_valid  (v[0]),
    .io_req0_ready  (rdy0),
    .io_req0_write  (w[0]),
    .io_req0_adr    (a[0]),
    .io_req0_wdata  (wd[0]),
    .io_req0_wstrb  (ws[0]),
    .io_req1_valid  (v[1]),
    .io_req1_ready  (rdy1),
    .io_req1_write  (w[1]),
    .io_req1_adr    (a[1]),
    .io_req1_wdata  (wd[1]),
    .io_req1_wstrb  (ws[1]),
    .io_resp0_valid (rv0),
    .io_resp0_ready (pr[0]),
    .io_resp0_rdata (rd0),
    .io_resp1_valid (rv1),
    .io_resp1_ready (pr[1]),
    .io_resp1_rdata (rd1),
    .io_sram_cen    (cen),
    .io_sram_wen    (wen),
    .io_sram_wstrb  (swstrb),
    .io_sram_adr    (sadr),
    .io_sram_d      (sd),
    .io_sram_q      (q)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM model: active-low cen/wen, byte strobes, one-cycle read latency
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {24'hABCDEF, 8'(i)};
      ref_mem[i] = {24'hABCDEF, 8'(i)};
    end
    mem[8'h10]     = 32'hAABBCCDD;
    ref_mem[8'h10] = 32'hAABBCCDD;
  end

  always @(posedge clock) begin
    if (!cen) begin
      if (!wen) mem[sadr] <= merge(mem[sadr], sd, swstrb);
      else      q <= mem[sadr];
    end
  end

  // Reference model: one outstanding-response slot per port, round-robin by last winner
  logic        m_has [2] = '{1'b0, 1'b0};
  logic [31:0] m_data [2];
  int          m_last = 1;
  int          g_s = -1;
  logic        rst_s = 1'b1;
  logic [1:0]  s_w, s_pr;
  logic [7:0]  s_a [2];
  logic [31:0] s_wd [2];
  logic [3:0]  s_ws [2];
  logic [1:0]  fire = 2'b00;

  always @(negedge clock) begin : compare
    int   g;
    logic e0, e1;
    g = -1;
    if (!reset) begin
      e0 = v[0] && (w[0] || !m_has[0] || pr[0]);
      e1 = v[1] && (w[1] || !m_has[1] || pr[1]);
      if (e0 && e1) g = (m_last == 1) ? 0 : 1;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
    end
    chk("ready0", rdy0, g == 0);
    chk("ready1", rdy1, g == 1);
    chk("resp_valid0", rv0, m_has[0] && !reset);
    chk("resp_valid1", rv1, m_has[1] && !reset);
    if (m_has[0] && !reset) chk("resp_rdata0", rd0, m_data[0]);
    if (m_has[1] && !reset) chk("resp_rdata1", rd1, m_data[1]);
    if (g < 0) begin
      chk("sram_idle", {cen, wen, swstrb, sadr, sd[17:0]}, {2'b11, 4'h0, 8'h0, 18'h0});
      chk("sram_idle_d", sd, 32'h0);
    end else begin
      chk("sram_cen", cen, 1'b0);
      chk("sram_wen", wen, !w[g]);
      chk("sram_adr", sadr, a[g]);
      chk("sram_d", sd, wd[g]);
      chk("sram_wstrb", swstrb, w[g] ? ws[g] : 4'h0);
    end
    g_s   <= g;
    rst_s <= reset;
    s_w   <= w;
    s_pr  <= pr;
    s_a   <= a;
    s_wd  <= wd;
    s_ws  <= ws;
    fire  <= {v[1] & rdy1, v[0] & rdy0};
  end

  always @(posedge clock) begin : model
    if (rst_s) begin
      m_has  <= '{1'b0, 1'b0};
      m_last <= 1;
    end else begin
      for (int n = 0; n < 2; n++) if (m_has[n] && s_pr[n]) m_has[n] <= 1'b0;
      if (g_s >= 0) begin
        m_last <= g_s;
        if (!s_w[g_s]) begin
          m_has[g_s]  <= 1'b1;
          m_data[g_s] <= ref_mem[s_a[g_s]];
        end else begin
          ref_mem[s_a[g_s]] <= merge(ref_mem[s_a[g_s]], s_wd[g_s], s_ws[g_s]);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = 2'b00;
    repeat (2) nxt();
    reset = 1'b0;
  endtask

  task automatic rd(input int n, input logic [7:0] adr);
    v[n] = 1'b1; w[n] = 1'b0; a[n] = adr;
  endtask

  task automatic wr(input int n, input logic [7:0] adr, input logic [31:0] d, input logic [3:0] s);
    v[n] = 1'b1; w[n] = 1'b1; a[n] = adr; wd[n] = d; ws[n] = s;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      a[n] = 8'h0; wd[n] = 32'h0; ws[n] = 4'h0;
    end
    nxt(); nxt();
    mid();
    chk("rst_cen", cen, 1'b1);
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_resp_valid0", rv0, 1'b0);
    nxt();
    reset = 1'b0;

    // single read after reset
    rd(0, 8'h05);
    mid();
    chk("t1_ready0", rdy0, 1'b1);
    chk("t1_adr", sadr, 8'h05);
    nxt();
    v[0] = 1'b0;
    mid();
    chk("t1_resp_valid0", rv0, 1'b1);
    chk("t1_rdata0", rd0, 32'hABCDEF05);
    chk("t1_cen_after", cen, 1'b1);
    nxt();

    // both ports read continuously: strict alternation starting at port 0
    do_reset();
    rd(0, 8'h01);
    rd(1, 8'h02);
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("alt_ready0", rdy0, (k % 2) == 0);
      chk("alt_ready1", rdy1, (k % 2) == 1);
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          chk("alt_resp_valid0", rv0, 1'b1);
          chk("alt_rdata0", rd0, 32'hABCDEF01);
        end else begin
          chk("alt_resp_valid1", rv1, 1'b1);
          chk("alt_rdata1", rd1, 32'hABCDEF02);
        end
      end
      nxt();
    end
    v = 2'b00;
    nxt();

    // byte-strobe write then read-back of the same word
    wr(1, 8'h10, 32'h11223344, 4'b0101);
    mid();
    chk("t3_wen_write", wen, 1'b0);
    chk("t3_ready1", rdy1, 1'b1);
    nxt();
    rd(1, 8'h10);
    mid();
    chk("t3_wen_read", wen, 1'b1);
    chk("t3_cen_read", cen, 1'b0);
    nxt();
    v[1] = 1'b0;
    mid();
    chk("t3_resp_valid1", rv1, 1'b1);
    chk("t3_rdata1", rd1, 32'hAA22CC44);
    nxt();

    // response back-pressure on port 0 while port 1 keeps reading
    pr[0] = 1'b0;
    rd(0, 8'h03);
    mid();
    chk("t4_ready0", rdy0, 1'b1);
    nxt();
    rd(0, 8'h04);
    rd(1, 8'h06);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t4_hold_valid0", rv0, 1'b1);
      chk("t4_hold_rdata0", rd0, 32'hABCDEF03);
      chk("t4_hold_ready0", rdy0, 1'b0);
      chk("t4_p1_ready", rdy1, 1'b1);
      nxt();
    end
    pr[0] = 1'b1;
    mid();
    chk("t4_release_rdata0", rd0, 32'hABCDEF03);
    chk("t4_release_ready0", rdy0, 1'b1);
    chk("t4_release_ready1", rdy1, 1'b0);
    nxt();
    v = 2'b00;
    mid();
    chk("t4_next_valid0", rv0, 1'b1);
    chk("t4_next_rdata0", rd0, 32'hABCDEF04);
    nxt();

    // back-to-back reads on port 0, no bubbles
    for (int k = 0; k < 5; k++) begin
      if (k < 4) rd(0, 8'(8 + k));
      else       v[0] = 1'b0;
      mid();
      if (k < 4) chk("b2b_ready0", rdy0, 1'b1);
      if (k > 0) begin
        chk("b2b_valid0", rv0, 1'b1);
        chk("b2b_rdata0", rd0, {24'hABCDEF, 8'(8 + k - 1)});
      end
      nxt();
    end

    // reset right after a read grant drops the pending response
    do_reset();
    rd(0, 8'h05);
    mid();
    chk("t6_ready0", rdy0, 1'b1);
    nxt();
    v[0] = 1'b0;
    reset = 1'b1;
    mid();
    chk("t6_valid0_in_reset", rv0, 1'b0);
    chk("t6_cen_in_reset", cen, 1'b1);
    nxt();
    mid();
    chk("t6_valid0_in_reset2", rv0, 1'b0);
    nxt();
    reset = 1'b0;
    rd(0, 8'h07);
    rd(1, 8'h09);
    mid();
    chk("t6_valid0_after", rv0, 1'b0);
    chk("t6_first_grant0", rdy0, 1'b1);
    chk("t6_first_grant1", rdy1, 1'b0);
    nxt();
    v = 2'b00;
    nxt();

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || fire[n]) begin
          v[n]  = ($urandom_range(0, 3) != 0);
          w[n]  = ($urandom_range(0, 3) == 0);
          a[n]  = 8'($urandom_range(0, 15));
          wd[n] = $urandom;
          ws[n] = 4'($urandom_range(0, 15));
        end
        pr[n] = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 199) == 0);
      nxt();
    end
    reset = 1'b0;
    v = 2'b00;
    pr = 2'b11;
    nxt();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
